// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
package ssd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PREP = 1'b1
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active high before any inversion.
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Hex digit to segment pattern; values above 9 render as A..F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_bin2ssd.sv
// Single-digit seven-segment decoder with blank, ripple-zero and minus controls.
module bin2ssd
  import ssd_pkg::*;
#(
  parameter logic INVERT = 1'b0
) (
  input  logic [3:0] b,
  input  logic       bi,
  input  logic       rz,
  input  logic       mi,
  output logic [6:0] seg
);

  logic [6:0] seg_raw;

  // Minus has priority over blanking, blanking over the digit pattern.
  always_comb begin
    seg_raw = hex_to_seg(b);
    if (mi) begin
      seg_raw = SEG_MINUS;
    end else if (bi || (rz && (b == 4'd0))) begin
      seg_raw = SEG_BLANK;
    end
  end

  assign seg = INVERT ? ~seg_raw : seg_raw;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment display controller: prepares blank/minus masks for a
// loaded BCD value one digit per cycle, then scans the shadow image onto the anodes.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYC    = 4,
  parameter logic        AN_INVERT   = 1'b0,
  parameter logic        SEG_INVERT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   neg,
  input  logic                   blank_en,
  output logic                   busy,
  output logic                   neg_ovf,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg
);

  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [NDIGITS-1:0] BLANK_RST = ~NDIGITS'(1);

  // Preparation state and work registers
  state_t                 state_q;
  logic                   busy_q;
  logic                   neg_ovf_q;
  logic [4*NDIGITS-1:0]   wval_q;
  logic                   wneg_q;
  logic                   wbe_q;
  logic [IDX_W-1:0]       pidx_q;
  logic                   chain_q;
  logic [NDIGITS-1:0]     wblank_q;

  // Shadow image being displayed
  logic [4*NDIGITS-1:0]   sh_dig_q;
  logic [NDIGITS-1:0]     sh_blank_q;
  logic [NDIGITS-1:0]     sh_minus_q;

  // Scanner
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       dig_q;

  // Per-cycle evaluation of the digit under preparation
  logic [3:0]             cur_digit;
  logic                   cur_blank;
  logic [NDIGITS-1:0]     blank_next;
  logic [NDIGITS-1:0]     minus_sel;
  logic                   place_minus;

  // Evaluate the digit at pidx_q against the running blank chain.
  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (IDX_W'(i) == pidx_q) begin
        cur_digit = wval_q[4*i +: 4];
      end
    end
    cur_blank   = wbe_q && (pidx_q != '0) && (cur_digit == 4'd0) && chain_q;
    blank_next  = wblank_q | (NDIGITS'(cur_blank) << pidx_q);
    // Blanked digits form a contiguous run from the top, so the lowest set bit
    // of the mask is the lowest-index blanked digit.
    minus_sel   = blank_next & (~blank_next + NDIGITS'(1));
    place_minus = wneg_q && (|wval_q);
  end

  // Load/prepare FSM with registered busy and neg_ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      neg_ovf_q  <= 1'b0;
      wval_q     <= '0;
      wneg_q     <= 1'b0;
      wbe_q      <= 1'b0;
      pidx_q     <= '0;
      chain_q    <= 1'b1;
      wblank_q   <= '0;
      sh_dig_q   <= '0;
      sh_blank_q <= BLANK_RST;
      sh_minus_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            wval_q   <= value;
            wneg_q   <= neg;
            wbe_q    <= blank_en;
            pidx_q   <= LAST_IDX;
            chain_q  <= 1'b1;
            wblank_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_PREP;
          end
        end
        ST_PREP: begin
          wblank_q <= blank_next;
          chain_q  <= cur_blank;
          pidx_q   <= pidx_q - IDX_W'(1);
          if (pidx_q == '0) begin
            sh_dig_q   <= wval_q;
            sh_blank_q <= blank_next;
            sh_minus_q <= place_minus ? minus_sel : '0;
            neg_ovf_q  <= place_minus && (blank_next == '0);
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Refresh counter and digit index, free-running regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dig_q <= '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_q <= '0;
      dig_q <= (dig_q == LAST_IDX) ? '0 : dig_q + IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  logic [3:0]         act_dig;
  logic               act_blank;
  logic               act_minus;
  logic [NDIGITS-1:0] an_raw;

  // Select the shadow entry for the active digit and form the anode pattern.
  always_comb begin
    act_dig   = '0;
    act_blank = 1'b0;
    act_minus = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (IDX_W'(i) == dig_q) begin
        act_dig   = sh_dig_q[4*i +: 4];
        act_blank = sh_blank_q[i];
        act_minus = sh_minus_q[i];
      end
    end
    an_raw = (cnt_q < CNT_W'(DEAD_CYC)) ? '0 : (NDIGITS'(1) << dig_q);
  end

  bin2ssd #(
    .INVERT (SEG_INVERT)
  ) u_dec (
    .b   (act_minus ? 4'd0 : act_dig),
    .bi  (act_minus | act_blank),
    .rz  (1'b0),
    .mi  (act_minus),
    .seg (seg)
  );

  assign an      = AN_INVERT ? ~an_raw : an_raw;
  assign busy    = busy_q;
  assign neg_ovf = neg_ovf_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with NDIGITS=4, REFRESH_DIV=8, DEAD_CYC=2.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        neg = 1'b0;
  logic        blank_en = 1'b0;
  logic        busy;
  logic        neg_ovf;
  logic [3:0]  an;
  logic [6:0]  seg;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .NDIGITS     (4),
    .REFRESH_DIV (8),
    .DEAD_CYC    (2),
    .AN_INVERT   (1'b0),
    .SEG_INVERT  (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .neg      (neg),
    .blank_en (blank_en),
    .busy     (busy),
    .neg_ovf  (neg_ovf),
    .an       (an),
    .seg      (seg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for each digit slot and check its segment pattern.
  task automatic check_disp(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] exp [4];
    logic [3:0] oh;
    int n;
    exp[0] = s0; exp[1] = s1; exp[2] = s2; exp[3] = s3;
    for (int d = 0; d < 4; d++) begin
      oh = 4'b0001 << d;
      n = 0;
      while (an !== oh && n < 64) begin
        @(negedge clk); #1;
        n++;
      end
      chk($sformatf("%s an%0d", tag, d), {28'd0, an}, {28'd0, oh});
      chk($sformatf("%s seg%0d", tag, d), {25'd0, seg}, {25'd0, exp[d]});
    end
  endtask

  // Issue one load and check busy lasts exactly 4 cycles, old neg_ovf held meanwhile.
  task automatic do_load(input string tag, input logic [15:0] v, input logic n,
                         input logic be, input logic prev_ovf);
    @(negedge clk);
    value = v; neg = n; blank_en = be; load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
    chk($sformatf("%s busy0", tag), {31'd0, busy}, 32'd1);
    chk($sformatf("%s hold ovf", tag), {31'd0, neg_ovf}, {31'd0, prev_ovf});
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("%s busy%0d", tag, i), {31'd0, busy}, 32'd1);
    end
    @(negedge clk); #1;
    chk($sformatf("%s done", tag), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an_exp;
    logic [6:0] seg_exp;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ovf", {31'd0, neg_ovf}, 32'd0);
    chk("rst an", {28'd0, an}, 32'd0);

    // Scan after reset release: 8 cycles per slot, first 2 dark, display "   0"
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) begin
      an_exp  = ((k % 8) < 2) ? 4'b0000 : (4'b0001 << (k / 8));
      seg_exp = ((k / 8) == 0) ? 7'h3F : 7'h00;
      chk($sformatf("scan an k%0d", k), {28'd0, an}, {28'd0, an_exp});
      chk($sformatf("scan seg k%0d", k), {25'd0, seg}, {25'd0, seg_exp});
      @(negedge clk); #1;
    end

    // "  42"
    do_load("l42", 16'h0042, 1'b0, 1'b1, 1'b0);
    chk("l42 ovf", {31'd0, neg_ovf}, 32'd0);
    check_disp("l42", 7'h00, 7'h00, 7'h66, 7'h5B);

    // " -42"
    do_load("m42", 16'h0042, 1'b1, 1'b1, 1'b0);
    chk("m42 ovf", {31'd0, neg_ovf}, 32'd0);
    check_disp("m42", 7'h00, 7'h40, 7'h66, 7'h5B);

    // "1234" with overflow
    do_load("m1234", 16'h1234, 1'b1, 1'b1, 1'b0);
    chk("m1234 ovf", {31'd0, neg_ovf}, 32'd1);
    check_disp("m1234", 7'h06, 7'h5B, 7'h4F, 7'h66);

    // No blanking: "0042" with overflow
    do_load("nb42", 16'h0042, 1'b1, 1'b0, 1'b1);
    chk("nb42 ovf", {31'd0, neg_ovf}, 32'd1);
    check_disp("nb42", 7'h3F, 7'h3F, 7'h66, 7'h5B);

    // Negative zero: "   0", no overflow
    do_load("mz", 16'h0000, 1'b1, 1'b1, 1'b1);
    chk("mz ovf", {31'd0, neg_ovf}, 32'd0);
    check_disp("mz", 7'h00, 7'h00, 7'h00, 7'h3F);

    // Second load pulse during PREP is ignored: "-905"
    @(negedge clk);
    value = 16'h0905; neg = 1'b1; blank_en = 1'b1; load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
    chk("ign busy0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    value = 16'h1234; neg = 1'b1; blank_en = 1'b0; load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
    chk("ign busy2", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    chk("ign busy3", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    chk("ign done", {31'd0, busy}, 32'd0);
    chk("ign ovf", {31'd0, neg_ovf}, 32'd0);
    check_disp("ign", 7'h40, 7'h6F, 7'h3F, 7'h6D);

    // Reset mid-PREP abandons preparation
    do_load("pre", 16'h1234, 1'b1, 1'b1, 1'b0);
    chk("pre ovf", {31'd0, neg_ovf}, 32'd1);
    @(negedge clk);
    value = 16'h0042; neg = 1'b0; blank_en = 1'b1; load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
    @(negedge clk); #1;
    chk("mid busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst ovf", {31'd0, neg_ovf}, 32'd0);
    chk("mid rst an", {28'd0, an}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_disp("mid", 7'h00, 7'h00, 7'h00, 7'h3F);
    chk("mid after busy", {31'd0, busy}, 32'd0);
    chk("mid after ovf", {31'd0, neg_ovf}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
